// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// access-size decode and store byte-enable patterns.
package lsu_pkg;

   typedef enum logic [2:0] {
      OpByte   = 3'b000,
      OpHalf   = 3'b001,
      OpWord   = 3'b010,
      OpByteU  = 3'b100,
      OpHalfU  = 3'b101
   } mem_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp
   } lsu_state_e;

   localparam logic [3:0] BeByte = 4'b0001;
   localparam logic [3:0] BeHalf = 4'b0011;
   localparam logic [3:0] BeWord = 4'b1111;

   // Byte count of an access; funct3[2] only selects zero-extension.
   function automatic logic [2:0] op_size(input logic [2:0] funct3);
      unique case (funct3[1:0])
         2'b00:   op_size = 3'd1;
         2'b01:   op_size = 3'd2;
         default: op_size = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extension: selects and sign/zero-extends the low byte, halfword
// or full word of the raw RAM word according to the load funct3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   always_comb begin
      data = raw;
      case (funct3)
         OpByte:  data = {{24{raw[7]}}, raw[7:0]};
         OpByteU: data = {24'h0, raw[7:0]};
         OpHalf:  data = {{16{raw[15]}}, raw[15:0]};
         OpHalfU: data = {16'h0, raw[15:0]};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit driving port B of the byte-addressed data RAM, one request in flight.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_DEPTH = 8192,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        req_funct3_i,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              ram_en_o,
   output logic [3:0]        ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_wdata_o,
   input  logic [31:0]       ram_rdata_i
);

   localparam logic [ADDR_W:0] DepthW = (ADDR_W+1)'(DATA_DEPTH);

   lsu_state_e        state_q;
   logic [2:0]        funct3_q;
   logic              we_q;
   logic              err_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              ram_en_q;
   logic [3:0]        ram_we_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [31:0]       ram_wdata_q;

   logic [2:0]        size;
   logic [ADDR_W:0]   addr_last;
   logic              legal;
   logic              in_range;
   logic              aligned;
   logic              accept;
   logic [3:0]        be;
   logic [31:0]       load_data;

   // Last byte address is formed one bit wider so a request near 2^ADDR_W cannot wrap.
   always_comb begin
      size      = op_size(req_funct3_i);
      addr_last = {1'b0, req_addr_i} + (ADDR_W+1)'(size) - (ADDR_W+1)'(1);
      in_range  = addr_last < DepthW;
      if (req_we_i) begin
         legal = req_funct3_i inside {OpByte, OpHalf, OpWord};
      end else begin
         legal = req_funct3_i inside {OpByte, OpHalf, OpWord, OpByteU, OpHalfU};
      end
`ifdef LSU_MISALIGN_TRAP_EN
      unique case (size)
         3'd2:    aligned = ~req_addr_i[0];
         3'd4:    aligned = req_addr_i[1:0] == 2'b00;
         default: aligned = 1'b1;
      endcase
`else
      aligned = 1'b1;
`endif
      accept = legal & in_range & aligned;
      unique case (size)
         3'd1:    be = BeByte;
         3'd2:    be = BeHalf;
         default: be = BeWord;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         funct3_q    <= 3'b000;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 4'b0000;
         ram_addr_q  <= '0;
         ram_wdata_q <= 32'h0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  funct3_q    <= req_funct3_i;
                  we_q        <= req_we_i;
                  ram_addr_q  <= req_addr_i;
                  ram_wdata_q <= req_wdata_i;
                  req_ready_q <= 1'b0;
                  if (accept) begin
                     ram_en_q <= 1'b1;
                     ram_we_q <= req_we_i ? be : 4'b0000;
                     state_q  <= StIssue;
                  end else begin
                     err_q       <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= StResp;
                  end
               end
            end
            StIssue: begin
               ram_en_q    <= 1'b0;
               ram_we_q    <= 4'b0000;
               rsp_valid_q <= 1'b1;
               state_q     <= StResp;
            end
            StResp: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  err_q       <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   lsu_load_align u_load_align (
      .funct3 (funct3_q),
      .raw    (ram_rdata_i),
      .data   (load_data)
   );

   // RAM output is held steady in RESP because port B stays disabled there.
   assign rsp_rdata_o = (rsp_valid_q && !we_q && !err_q) ? load_data : 32'h0;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = err_q;
   assign req_ready_o = req_ready_q;
   assign ram_en_o    = ram_en_q;
   assign ram_we_o    = ram_we_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_wdata_o = ram_wdata_q;

endmodule
